// File: rtl/ascii_line_sender.sv
// Serialises a snapshotted NUM_CHARS-byte ASCII vector to a UART Tx core, ending each line with CR LF.
// Optional macro ASCII_LINE_SENDER_CHECKSUM_EN inserts ",HH" (XOR checksum in hex) before CR LF.
module ascii_line_sender #(
    parameter int NUM_CHARS = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   iSTART,
    input  logic [NUM_CHARS*8-1:0] iASCII,
    output logic                   oBUSY,
    output logic [7:0]             oTX_DATA,
    output logic                   oTX_VALID,
    input  logic                   iTX_READY,
    output logic                   oDONE,
    output logic [2:0]             dbg_state
);

    localparam int IW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SEND_CHAR  = 3'd1,
        SEND_CR    = 3'd2,
        SEND_LF    = 3'd3,
        SEND_SEP   = 3'd4,
        SEND_CK_HI = 3'd5,
        SEND_CK_LO = 3'd6
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [NUM_CHARS*8-1:0] shadow;
    logic [IW-1:0]          idx;
    logic                   done;
    logic                   start_ok;
    logic                   xfer;
    logic [7:0]             char_byte;

    // Valid/ready: a byte moves on a rising edge with oTX_VALID && iTX_READY;
    // oTX_DATA/oTX_VALID hold until then and the next byte follows immediately.
    assign start_ok  = (state == IDLE) && iSTART;
    assign xfer      = oTX_VALID && iTX_READY;
    assign char_byte = shadow[{idx, 3'b000} +: 8];
    assign oDONE     = done;
    assign dbg_state = state;

`ifdef ASCII_LINE_SENDER_CHECKSUM_EN
    logic [7:0] cksum;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            hex_char = 8'h30 + {4'h0, nib};
        end else begin
            hex_char = 8'h37 + {4'h0, nib};
        end
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cksum <= 8'h00;
        end else if (start_ok) begin
            cksum <= 8'h00;
        end else if (state == SEND_CHAR && xfer) begin
            cksum <= cksum ^ char_byte;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            shadow <= '0;
            idx    <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == SEND_LF) && xfer;
            if (start_ok) begin
                shadow <= iASCII;
                idx    <= IW'(NUM_CHARS - 1);
            end else if (state == SEND_CHAR && xfer && idx != '0) begin
                idx <= idx - 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        oBUSY      = 1'b0;
        oTX_VALID  = 1'b0;
        oTX_DATA   = 8'h00;
        case (state)
            IDLE: begin
                if (start_ok) state_next = SEND_CHAR;
            end
            SEND_CHAR: begin
                oBUSY     = 1'b1;
                oTX_VALID = 1'b1;
                oTX_DATA  = char_byte;
                if (xfer && idx == '0) begin
`ifdef ASCII_LINE_SENDER_CHECKSUM_EN
                    state_next = SEND_SEP;
`else
                    state_next = SEND_CR;
`endif
                end
            end
`ifdef ASCII_LINE_SENDER_CHECKSUM_EN
            SEND_SEP: begin
                oBUSY     = 1'b1;
                oTX_VALID = 1'b1;
                oTX_DATA  = 8'h2C;
                if (xfer) state_next = SEND_CK_HI;
            end
            SEND_CK_HI: begin
                oBUSY     = 1'b1;
                oTX_VALID = 1'b1;
                oTX_DATA  = hex_char(cksum[7:4]);
                if (xfer) state_next = SEND_CK_LO;
            end
            SEND_CK_LO: begin
                oBUSY     = 1'b1;
                oTX_VALID = 1'b1;
                oTX_DATA  = hex_char(cksum[3:0]);
                if (xfer) state_next = SEND_CR;
            end
`endif
            SEND_CR: begin
                oBUSY     = 1'b1;
                oTX_VALID = 1'b1;
                oTX_DATA  = 8'h0D;
                if (xfer) state_next = SEND_LF;
            end
            SEND_LF: begin
                oBUSY     = 1'b1;
                oTX_VALID = 1'b1;
                oTX_DATA  = 8'h0A;
                if (xfer) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/ascii_line_sender.md
Name: ascii_line_sender

Overview:
Consumes the registered hex-ASCII character vector from the nibble-to-ASCII converter and serialises it, one byte per transfer, to the UART Tx core, terminating each line with CR LF. It sits between the hex-ASCII conversion stage and the UART transmitter in the EyeTracker debug/telemetry path. A start strobe snapshots the whole character vector, so the upstream value may change while the line is in flight.

Parameters:
NUM_CHARS, 4, number of ASCII characters per line (NUM_CHARS*8 = width of iASCII); legal range 1..16

Ports:
CLK        input   1              system clock, all logic rising-edge
RST_N      input   1              asynchronous active-low reset
iSTART     input   1              one-cycle request to send the current iASCII as one line
iASCII     input   NUM_CHARS*8    ASCII characters; first character sent = iASCII[NUM_CHARS*8-1 -: 8]
oBUSY      output  1              high from the cycle after an accepted start until the line completes
oTX_DATA   output  8              byte offered to the UART Tx core
oTX_VALID  output  1              oTX_DATA is valid
iTX_READY  input   1              UART Tx core accepts the byte this cycle
oDONE      output  1              one-cycle pulse when the final LF has been accepted

Behaviour:
- Interface: one clock (CLK); reset is asynchronous and active-low (RST_N).
- Reset values: oBUSY=0, oTX_VALID=0, oTX_DATA=8'h00, oDONE=0, FSM=IDLE, character index=0, shadow register=0.
- FSM states: IDLE, SEND_CHAR, SEND_CR, SEND_LF (plus SEND_SEP, SEND_CK_HI, SEND_CK_LO when the optional feature is compiled in).
- IDLE: iSTART=1 latches iASCII into the shadow register and sets index=NUM_CHARS-1.
  - Next cycle: state=SEND_CHAR, oBUSY=1, oTX_VALID=1, oTX_DATA=first character.
  - Start-to-first-valid latency is 1 cycle.
- Handshake:
  - A byte transfers on any rising edge where oTX_VALID && iTX_READY.
  - oTX_DATA and oTX_VALID stay stable until that transfer; no bubble cycles.
  - The next byte is presented in the cycle immediately after a transfer.
  - iTX_READY is ignored while oTX_VALID=0.
- SEND_CHAR: on each transfer, index decrements. The transfer at index 0 moves to SEND_CR, presenting 8'h0D.
- SEND_CR: on transfer, moves to SEND_LF, presenting 8'h0A.
- SEND_LF: on transfer, moves to IDLE in the next cycle with oTX_VALID=0, oBUSY=0 and oDONE=1 for that single cycle.
- Line length is NUM_CHARS+2 bytes. Minimum line duration with iTX_READY held high is NUM_CHARS+2 cycles.
- Start while busy: iSTART with oBUSY=1 is ignored. It is not queued, and the shadow register is unchanged.
- Start in the oDONE cycle: accepted, since the FSM is in IDLE. This gives back-to-back lines with one idle cycle between them.
- Reset mid-line: aborts immediately. All outputs take their reset values, no oDONE is generated, and no partial state survives.
- Character content is not checked; any byte value is forwarded as-is.

Optional Feature:
Macro: ASCII_LINE_SENDER_CHECKSUM_EN
- Defined:
  - A running 8-bit XOR of all NUM_CHARS data bytes is accumulated as they are latched.
  - After the last data byte, the block sends ',' (8'h2C), then the checksum high nibble, then the low nibble, then CR LF.
  - Nibbles are encoded as uppercase hex ASCII: 0-9 → 8'h30-8'h39, A-F → 8'h41-8'h46.
  - Line length becomes NUM_CHARS+5 bytes.
  - The checksum register clears on every accepted start and on reset.
- Undefined: none of this logic exists, and the line is data bytes followed by CR LF only.

Test Plan:
1. NUM_CHARS=4, iASCII=32'h3141_3246 ("1A2F"), iTX_READY=1, one iSTART pulse → bytes 31,41,32,46,0D,0A on 6 consecutive cycles starting 1 cycle after iSTART; oDONE pulses 1 cycle after the 0A transfer.
2. Same stimulus with iTX_READY low for 3 cycles on each byte → oTX_DATA/oTX_VALID stable throughout each stall; same 6-byte sequence; no duplicated or dropped bytes.
3. Second iSTART with iASCII=32'h3030_3030 asserted while the line "1A2F" is in flight → ignored; "1A2F\r\n" completes unchanged; exactly one oDONE.
4. RST_N low after the 2nd byte transfers → oTX_VALID=0 and oBUSY=0 asynchronously; no oDONE; a fresh start then sends the full line from the first character.
5. iSTART asserted in the oDONE cycle with iASCII=32'h3030_3039 → accepted; "0009\r\n" follows with a single idle cycle between lines.
6. With ASCII_LINE_SENDER_CHECKSUM_EN defined, iASCII="1A2F" → bytes 31,41,32,46,2C,30,34,0D,0A (checksum 8'h04).
